// File: rtl/huffman_region_sequencer_if.sv
// Signal bundle between the bitstream reader, the Huffman table bank and the
// region sequencer; clk/rst stay outside the bundle.
interface huffman_region_sequencer_if #(
  parameter int IDX_W  = 9,
  parameter int BITS_W = 12
);
  logic                     start;
  logic [IDX_W-1:0]         big_values;
  logic [IDX_W-1:0]         region1_start;
  logic [IDX_W-1:0]         region2_start;
  logic [4:0]               table_select0;
  logic [4:0]               table_select1;
  logic [4:0]               table_select2;
  logic                     axiiv;
  logic                     axiid;
  logic                     in_ready;
  logic [4:0]               ht_sel;
  logic                     dec_rst;
  logic                     dec_axiiv;
  logic                     dec_axiid;
  logic                     dec_axiov;
  logic signed [15:0]       dec_x;
  logic signed [15:0]       dec_y;
  logic                     pair_valid;
  logic signed [15:0]       pair_x;
  logic signed [15:0]       pair_y;
  logic [IDX_W-1:0]         pair_idx;
  logic [1:0]               region;
  logic [BITS_W-1:0]        bits_used;
  logic                     busy;
  logic                     done;
  logic                     tbl_err;

  modport slave (
    input  start, big_values, region1_start, region2_start,
           table_select0, table_select1, table_select2,
           axiiv, axiid, dec_axiov, dec_x, dec_y,
    output in_ready, ht_sel, dec_rst, dec_axiiv, dec_axiid,
           pair_valid, pair_x, pair_y, pair_idx, region,
           bits_used, busy, done, tbl_err
  );

  modport master (
    output start, big_values, region1_start, region2_start,
           table_select0, table_select1, table_select2,
           axiiv, axiid, dec_axiov, dec_x, dec_y,
    input  in_ready, ht_sel, dec_rst, dec_axiiv, dec_axiid,
           pair_valid, pair_x, pair_y, pair_idx, region,
           bits_used, busy, done, tbl_err
  );
endinterface

// File: rtl/huffman_region_sequencer.sv
// Sequences big_values Huffman decoding for one granule/channel: routes bits to
// the decoder of the current region, counts pairs and emits registered pairs.
module huffman_region_sequencer #(
  parameter int IDX_W  = 9,
  parameter int BITS_W = 12
) (
  input logic clk,
  input logic rst,
  huffman_region_sequencer_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_DECODE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state;
  logic [IDX_W-1:0] bv_q, r1_q, r2_q, cnt;
  logic [4:0]       ts0_q, ts1_q, ts2_q;

  logic [IDX_W-1:0] cnt_nx;
  logic [1:0]       rg_cur, rg_nx;
  logic [4:0]       cur_tbl;
  logic             zero_tbl, bad_tbl, last, hold, in_dec, in_ready, emit;

  function automatic logic [1:0] region_of(input logic [IDX_W-1:0] idx,
                                           input logic [IDX_W-1:0] r1,
                                           input logic [IDX_W-1:0] r2);
    if (idx < r1)      return 2'd0;
    else if (idx < r2) return 2'd1;
    else               return 2'd2;
  endfunction

  always_comb begin
    cnt_nx   = cnt + IDX_W'(1);
    rg_cur   = region_of(cnt, r1_q, r2_q);
    rg_nx    = region_of(cnt_nx, r1_q, r2_q);
    case (rg_cur)
      2'd0:    cur_tbl = ts0_q;
      2'd1:    cur_tbl = ts1_q;
      default: cur_tbl = ts2_q;
    endcase
    bad_tbl  = (cur_tbl == 5'd4) || (cur_tbl == 5'd14);
    zero_tbl = (cur_tbl == 5'd0) || bad_tbl;
    last     = (cnt_nx == bv_q);
    in_dec   = (state == S_DECODE);
    // Keep the next bit out of a decoder that is about to be retired
    hold     = bus.dec_axiov && (last || (rg_nx != rg_cur));
    in_ready = in_dec && !zero_tbl && !hold;
    emit     = in_dec && (zero_tbl || bus.dec_axiov);
  end

  assign bus.in_ready  = in_ready;
  assign bus.dec_axiiv = bus.axiiv && in_ready;
  assign bus.dec_axiid = bus.axiid;
  assign bus.ht_sel    = cur_tbl;
  assign bus.dec_rst   = rst || (state == S_SETUP);
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      bv_q           <= '0;
      r1_q           <= '0;
      r2_q           <= '0;
      ts0_q          <= '0;
      ts1_q          <= '0;
      ts2_q          <= '0;
      bus.bits_used  <= '0;
      bus.tbl_err    <= 1'b0;
      bus.pair_valid <= 1'b0;
      bus.pair_x     <= '0;
      bus.pair_y     <= '0;
      bus.pair_idx   <= '0;
      bus.region     <= '0;
    end else begin
      bus.pair_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            bv_q          <= bus.big_values;
            r1_q          <= bus.region1_start;
            r2_q          <= bus.region2_start;
            ts0_q         <= bus.table_select0;
            ts1_q         <= bus.table_select1;
            ts2_q         <= bus.table_select2;
            cnt           <= '0;
            bus.bits_used <= '0;
            bus.tbl_err   <= 1'b0;
            state         <= S_SETUP;
          end
        end
        S_SETUP: state <= (bv_q == '0) ? S_DONE : S_DECODE;
        S_DECODE: begin
          if (bus.axiiv && in_ready) bus.bits_used <= bus.bits_used + BITS_W'(1);
          // Pair capture stage: table 0/4/14 regions emit (0,0) without bits
          if (emit) begin
            bus.pair_valid <= 1'b1;
            bus.pair_x     <= zero_tbl ? '0 : bus.dec_x;
            bus.pair_y     <= zero_tbl ? '0 : bus.dec_y;
            bus.pair_idx   <= cnt;
            bus.region     <= rg_cur;
            cnt            <= cnt_nx;
            if (bad_tbl) bus.tbl_err <= 1'b1;
            if (last)    state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_huffman_region_sequencer.sv
// Scoreboard bench for huffman_region_sequencer with a behavioural table-1 decoder.
module tb_huffman_region_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  huffman_region_sequencer_if #(.IDX_W(9), .BITS_W(12)) bus();
  huffman_region_sequencer #(.IDX_W(9), .BITS_W(12)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic [8:0]         idx;
    logic [1:0]         rg;
    logic               last;
  } pair_t;

  pair_t exp_q[$];
  logic  exp_rdy_q[$];
  int    checks = 0;
  int    fails  = 0;
  logic  saw_rdy;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Table-1 decoder model: 1->(0,0) 01->(1,0) 001->(0,1) 000->(1,1), then sign bits
  logic               t1_done;
  logic signed [15:0] t1_x, t1_y;
  int                 ph, plen;
  always @(posedge clk) begin
    if (bus.dec_rst) begin
      t1_done <= 1'b0; ph <= 0; plen <= 0; t1_x <= '0; t1_y <= '0;
    end else begin
      t1_done <= 1'b0;
      if (bus.dec_axiiv) begin
        if (ph == 0) begin
          if (plen == 0) begin
            if (bus.dec_axiid) begin t1_x <= 0; t1_y <= 0; t1_done <= 1'b1; end
            else plen <= 1;
          end else if (plen == 1) begin
            if (bus.dec_axiid) begin t1_x <= 1; t1_y <= 0; ph <= 1; plen <= 0; end
            else plen <= 2;
          end else begin
            if (bus.dec_axiid) begin t1_x <= 0; t1_y <= 1; ph <= 2; end
            else begin t1_x <= 1; t1_y <= 1; ph <= 1; end
            plen <= 0;
          end
        end else if (ph == 1) begin
          if (bus.dec_axiid) t1_x <= -t1_x;
          if (t1_y != 0) ph <= 2;
          else begin ph <= 0; t1_done <= 1'b1; end
        end else begin
          if (bus.dec_axiid) t1_y <= -t1_y;
          ph <= 0; t1_done <= 1'b1;
        end
      end
    end
  end
  assign bus.dec_axiov = t1_done;
  assign bus.dec_x     = t1_x;
  assign bus.dec_y     = t1_y;

  // Monitor: pops the scoreboard on every emitted pair and every decoder-complete cycle
  always @(negedge clk) begin
    pair_t e;
    if (bus.in_ready) saw_rdy = 1'b1;
    if (bus.pair_valid) begin
      if (exp_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_pair: got idx %0d expected no pair", bus.pair_idx);
      end else begin
        e = exp_q.pop_front();
        chk("pair_x", bus.pair_x, $signed(e.x));
        chk("pair_y", bus.pair_y, $signed(e.y));
        chk("pair_idx", bus.pair_idx, e.idx);
        chk("pair_region", bus.region, e.rg);
        chk("done_with_pair", bus.done, e.last);
      end
    end
    if (bus.dec_axiov && bus.busy && !rst) begin
      if (exp_rdy_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_axiov: got in_ready %0d expected no decoder pair", bus.in_ready);
      end else chk("in_ready_on_axiov", bus.in_ready, exp_rdy_q.pop_front());
    end
  end

  task automatic push_pair(input int x, input int y, input int idx, input int rg, input bit last);
    pair_t p;
    p.x = 16'(x); p.y = 16'(y); p.idx = 9'(idx); p.rg = 2'(rg); p.last = last;
    exp_q.push_back(p);
  endtask

  task automatic do_start(input int bv, input int r1, input int r2,
                          input int t0, input int t1, input int t2);
    bus.big_values    = 9'(bv);
    bus.region1_start = 9'(r1);
    bus.region2_start = 9'(r2);
    bus.table_select0 = 5'(t0);
    bus.table_select1 = 5'(t1);
    bus.table_select2 = 5'(t2);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
    end while (!bus.done && cyc < 500);
    if (!bus.done) begin
      checks++; fails++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic feed(input logic [31:0] bits, input int n, input bit gaps);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 300) begin
      if (gaps && $urandom_range(0, 2) == 0) bus.axiiv = 1'b0;
      else begin bus.axiiv = 1'b1; bus.axiid = bits[n-1-i]; end
      @(negedge clk);
      if (bus.axiiv && bus.in_ready) i++;
      @(posedge clk); #1;
      guard++;
    end
    bus.axiiv = 1'b0;
    if (i < n) begin
      checks++; fails++;
      $display("FAIL feed_timeout: got %0d bits consumed expected %0d", i, n);
    end
  endtask

  initial begin
    int cyc;
    bus.start = 0; bus.axiiv = 0; bus.axiid = 0;
    bus.big_values = 0; bus.region1_start = 0; bus.region2_start = 0;
    bus.table_select0 = 0; bus.table_select1 = 0; bus.table_select2 = 0;
    saw_rdy = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_dec_rst", bus.dec_rst, 1);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_pair_valid", bus.pair_valid, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_dec_axiiv", bus.dec_axiiv, 0);
    chk("rst_tbl_err", bus.tbl_err, 0);
    chk("rst_pair_x", bus.pair_x, 0);
    chk("rst_pair_idx", bus.pair_idx, 0);
    chk("rst_region", bus.region, 0);
    chk("rst_ht_sel", bus.ht_sel, 0);
    chk("rst_bits_used", bus.bits_used, 0);
    chk("idle_dec_rst", bus.dec_rst, 0);
    @(posedge clk); #1;

    // big_values = 0
    saw_rdy = 0;
    do_start(0, 0, 0, 1, 1, 1);
    wait_done(cyc);
    chk("bv0_done_latency", cyc, 2);
    chk("bv0_in_ready_seen", saw_rdy, 0);
    chk("bv0_bits_used", bus.bits_used, 0);

    // table 1 only, bits 1 | 01 0
    exp_rdy_q.push_back(1'b1); exp_rdy_q.push_back(1'b0);
    push_pair(0, 0, 0, 0, 0); push_pair(1, 0, 1, 0, 1);
    do_start(2, 2, 2, 1, 0, 0);
    fork
      feed(32'b1010, 4, 1'b0);
      wait_done(cyc);
    join
    chk("t1_bits_used", bus.bits_used, 4);
    chk("t1_pairs_left", exp_q.size(), 0);

    // table 0: three (0,0) pairs on consecutive cycles
    push_pair(0, 0, 0, 0, 0); push_pair(0, 0, 1, 0, 0); push_pair(0, 0, 2, 0, 1);
    do_start(3, 3, 3, 0, 1, 1);
    wait_done(cyc);
    chk("t0_done_latency", cyc, 5);
    chk("t0_bits_used", bus.bits_used, 0);

    // region switch: table 1 for idx0, table 0 for idx1..2
    exp_rdy_q.push_back(1'b0);
    push_pair(0, 0, 0, 0, 0); push_pair(0, 0, 1, 1, 0); push_pair(0, 0, 2, 1, 1);
    do_start(3, 1, 3, 1, 0, 1);
    feed(32'b1, 1, 1'b0);
    @(negedge clk);
    chk("sw_ht_sel_before", bus.ht_sel, 1);
    chk("sw_in_ready", bus.in_ready, 0);
    @(negedge clk);
    chk("sw_ht_sel_after", bus.ht_sel, 0);
    wait_done(cyc);
    chk("sw_bits_used", bus.bits_used, 1);

    // table 1 with axiiv gaps; a start during DECODE must be ignored
    exp_rdy_q.push_back(1'b1); exp_rdy_q.push_back(1'b0);
    push_pair(0, 0, 0, 0, 0); push_pair(1, 0, 1, 0, 1);
    do_start(2, 2, 2, 1, 0, 0);
    fork
      feed(32'b1010, 4, 1'b1);
      wait_done(cyc);
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.big_values = 0; bus.table_select0 = 5'd4; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
    join
    chk("gap_bits_used", bus.bits_used, 4);
    chk("gap_tbl_err", bus.tbl_err, 0);
    chk("gap_busy_after", bus.busy, 0);

    // unused table 4
    push_pair(0, 0, 0, 0, 0); push_pair(0, 0, 1, 0, 1);
    do_start(2, 2, 2, 4, 1, 1);
    wait_done(cyc);
    chk("t4_tbl_err", bus.tbl_err, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("t4_tbl_err_sticky", bus.tbl_err, 1);

    // reset mid-DECODE, then a fresh decode
    do_start(2, 2, 2, 1, 0, 0);
    feed(32'b1, 1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_pair_valid", bus.pair_valid, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_bits_used", bus.bits_used, 0);
    chk("mid_rst_pair_idx", bus.pair_idx, 0);
    chk("mid_rst_ht_sel", bus.ht_sel, 0);
    chk("mid_rst_dec_rst", bus.dec_rst, 1);
    @(posedge clk); #1; rst = 1'b0;
    exp_rdy_q.push_back(1'b1); exp_rdy_q.push_back(1'b0);
    push_pair(0, -1, 0, 0, 0); push_pair(1, -1, 1, 0, 1);
    do_start(2, 2, 2, 1, 0, 0);
    fork
      feed(32'b001100001, 9, 1'b0);
      wait_done(cyc);
    join
    chk("post_rst_bits_used", bus.bits_used, 9);
    chk("post_rst_pairs_left", exp_q.size(), 0);
    chk("post_rst_axiov_left", exp_rdy_q.size(), 0);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/huffman_region_sequencer.md
# huffman_region_sequencer

Sequences MP3 big_values Huffman decoding for one granule/channel. It routes the serial bitstream into the table decoder selected for the current region (region0/1/2), counts decoded (x,y) pairs against the region boundaries and big_values, and emits registered pairs downstream. It sits between the bit reservoir/stream reader and the bank of per-table Huffman decoders (HT_n). An external mux selects the decoder by `ht_sel`.

## Interface
Parameters:
- `IDX_W`, default 9: width of pair counts and boundaries (max 288 pairs).
- `BITS_W`, default 12: width of the consumed-bit counter (part2_3_length range).

Ports:
- `clk`  in  1  clock; the block uses this one clock only.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle pulse; latches config; ignored unless IDLE.
- `big_values`  in  IDX_W  number of pairs to decode.
- `region1_start`, `region2_start`  in  IDX_W each  first pair index of region1/region2 (already converted from sfb to pairs upstream).
- `table_select0..2`  in  5 each  Huffman table per region.
- `axiiv`, `axiid`  in  1 each  serial bitstream valid/data from the reader.
- `in_ready`  out  1  bit is consumed this cycle iff `axiiv && in_ready`.
- `ht_sel`  out  5  table of the current region (mux select).
- `dec_rst`  out  1  reset to the decoder bank.
- `dec_axiiv`, `dec_axiid`  out  1 each  bit forwarded to the decoders.
- `dec_axiov`  in  1  selected decoder has a complete pair (combinational from decoder registers).
- `dec_x`, `dec_y`  in  16 signed each  selected decoder's values.
- `pair_valid`  out  1  one-cycle strobe per pair.
- `pair_x`, `pair_y`  out  16 signed each.
- `pair_idx`  out  IDX_W  index of the emitted pair.
- `region`  out  2  region of the emitted pair.
- `bits_used`  out  BITS_W  bits forwarded since `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse.
- `tbl_err`  out  1  sticky until next `start`; set when an unused table (4 or 14) is selected.

## Operation
- States: IDLE, SETUP, DECODE, DONE.
- **IDLE, `start` received:** latch all config inputs. Clear the pair counter `cnt`, `bits_used` and `tbl_err`. Go to SETUP.
- **SETUP (1 cycle):** `dec_rst=1` (clears residual decoder state). Go to DONE if `big_values==0`, else to DECODE.
- **Current region:** from `cnt`: 0 if `cnt<region1_start`; else 1 if `cnt<region2_start`; else 2. `ht_sel` is the table of that region.
- **DECODE, nonzero used table:**
  - `in_ready = !(dec_axiov && (cnt+1==big_values || region(cnt+1)!=region(cnt)))`.
  - `dec_axiiv = axiiv && in_ready`; `dec_axiid = axiid`; `bits_used` increments on each forwarded bit.
  - On `dec_axiov`: capture the pair and increment `cnt`.
  - Holding `in_ready` low on the last pair and on region-switch pairs keeps the bit presented in that cycle out of the old decoder; that bit goes to the new table next cycle.
- **DECODE, table 0 / 4 / 14:**
  - `in_ready=0`. Emit one (0,0) pair per cycle and increment `cnt`.
  - Tables 4 and 14 also set `tbl_err`.
- After the pair with `cnt+1==big_values` is captured, go to DONE.
- **DONE (1 cycle):** `done=1`, then return to IDLE.
- Boundaries at or above `big_values`: the region is never entered. Boundaries of 0: region0 is skipped. `region2_start<region1_start`: region1 is skipped (the region function above applies as written).
- `in_ready`, `dec_axiiv` are 0 outside DECODE. `ht_sel` holds its last value in IDLE.

## Timing
- **Reset values:** state IDLE, `cnt=0`, `bits_used=0`. Outputs `pair_valid`, `done`, `busy`, `in_ready`, `dec_axiiv`, `tbl_err` = 0. `pair_x`, `pair_y`, `pair_idx`, `region` = 0. `ht_sel=0`. `dec_rst=1` while `rst` is high.
- `rst` mid-operation: everything returns to the reset values on the next edge. No `done` pulse.
- `start` → SETUP on the next edge. DECODE is entered 2 cycles after the `start` edge.
- `pair_*` are registered: `pair_valid` goes high 1 cycle after the `dec_axiov` cycle (or after the table-0 emit cycle).
- `ht_sel` changes the cycle after the region-switch pair is captured.
- `done` is coincident with the last `pair_valid`. With `big_values=0`, `done` is high 2 cycles after `start`.
- `axiiv` gaps are legal at any point. Results are independent of gap placement.

## Test plan
- `big_values=0`, `start` → `done` 2 cycles later; no `pair_valid`; `bits_used=0`; `in_ready` never high.
- Table 1 only (`region1_start=region2_start=big_values=2`), bits 1,0,1,0 → pairs (0,0) idx0 and (+1,0) idx1; `bits_used=4`; `in_ready` low in the cycle `dec_axiov` flags idx1; `done` with the second `pair_valid`.
- `table_select0=0`, `big_values=3` → three (0,0) pairs on consecutive cycles, `region=0`, `bits_used=0`.
- `region1_start=1`, tables 1 then 0, `big_values=3`, bit 1 → idx0 (0,0) from table 1, `in_ready=0` on that `dec_axiov` cycle, `ht_sel` becomes 0 next cycle, idx1–2 are (0,0) with `region=1`.
- Repeat the table-1 case with random `axiiv` gaps → identical pairs and `bits_used`. A `start` pulsed during DECODE is ignored.
- `table_select0=4` → zero pairs and `tbl_err=1`. Assert `rst` mid-DECODE of a table-1 run → all outputs at reset values, and a fresh `start` decodes correctly.
